// File: rtl/adc_frame_writer.sv
// ADC frame packer: channel mask + decimation, two 16-bit samples per 32-bit word, ping-pong RAM ring.
// Optional ADC_FRAME_HDR_EN macro prepends a {16'hA5A5, seq} header word to every frame.
module adc_frame_writer #(
    parameter int unsigned CH_NUM  = 8,
    parameter int unsigned SMP_W   = 16,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DECIM_W = 8
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DECIM_W-1:0]        decim,
    input  logic [CH_NUM-1:0]         ch_mask,
    input  logic                      frame_valid,
    input  logic [CH_NUM*SMP_W-1:0]   frame_data,
    input  logic [1:0]                half_ack,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [31:0]               mem_wr_data,
    output logic [1:0]                half_ready,
    output logic                      overflow,
    output logic [15:0]               frame_cnt,
    output logic                      busy
);

    localparam int unsigned NWORD = (CH_NUM + 1) / 2;
    localparam int unsigned CW    = NWORD * 32;
    localparam int unsigned IDX_W = $clog2(NWORD + 2);
    localparam int unsigned CNT_W = $clog2(CH_NUM + 1);
`ifdef ADC_FRAME_HDR_EN
    localparam int unsigned HDR_WORDS = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`else
    localparam int unsigned HDR_WORDS = 0;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CW-1:0]       comp_q, comp_nxt, comp_c;
    logic [IDX_W-1:0]    ndata_q, ndata_nxt, ndata_c, words_c;
    logic [CNT_W-1:0]    pop_c;
    logic [ADDR_W-1:0]   wr_ptr, ptr_nxt, end_addr_c;
    logic [DECIM_W-1:0]  dec_cnt, dec_nxt, decim_q, decim_nxt;
    logic                en_q, en_rise_c;
    logic                ovf_nxt, wr_en_nxt, busy_nxt;
    logic [1:0]          hr_nxt;
    logic [15:0]         fcnt_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt;
    logic [31:0]         wr_data_nxt, word_c;
`ifdef ADC_FRAME_HDR_EN
    logic [15:0]         seq, seq_nxt;
`endif

    assign en_rise_c = enable & ~en_q;

    // Compact selected channels in ascending order, zero-extended to 16 bits
    always_comb begin
        int unsigned j;
        comp_c = '0;
        j      = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_mask[i]) begin
                comp_c[j*16 +: 16] = 16'(frame_data[i*SMP_W +: SMP_W]);
                j = j + 1;
            end
        end
        pop_c      = CNT_W'(j);
        ndata_c    = IDX_W'((j + 1) / 2);
        words_c    = ndata_c + IDX_W'(HDR_WORDS);
        end_addr_c = wr_ptr + ADDR_W'(words_c) - ADDR_W'(1);
        word_c     = comp_q[int'(idx)*32 +: 32];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        comp_nxt    = comp_q;
        ndata_nxt   = ndata_q;
        ptr_nxt     = wr_ptr;
        dec_nxt     = dec_cnt;
        decim_nxt   = decim_q;
        ovf_nxt     = overflow;
        fcnt_nxt    = frame_cnt;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = mem_wr_addr;
        wr_data_nxt = mem_wr_data;
`ifdef ADC_FRAME_HDR_EN
        seq_nxt     = seq;
`endif
        // Half flags: set by a write to the last word of a half, which beats a same-cycle ack
        hr_nxt = half_ready & ~half_ack;
        if (mem_wr_en && (&mem_wr_addr[ADDR_W-2:0])) begin
            hr_nxt[mem_wr_addr[ADDR_W-1]] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (enable && !en_rise_c && frame_valid) begin
                    dec_nxt = (dec_cnt == decim_q) ? '0 : dec_cnt + DECIM_W'(1);
                    if (dec_cnt == '0 && pop_c != '0) begin
                        if (half_ready[wr_ptr[ADDR_W-1]] || half_ready[end_addr_c[ADDR_W-1]]) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            comp_nxt    = comp_c;
                            ndata_nxt   = ndata_c;
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = wr_ptr;
                            ptr_nxt     = wr_ptr + ADDR_W'(1);
`ifdef ADC_FRAME_HDR_EN
                            wr_data_nxt = {16'hA5A5, seq};
                            idx_nxt     = '0;
                            state_nxt   = HDR;
`else
                            wr_data_nxt = comp_c[31:0];
                            idx_nxt     = IDX_W'(1);
                            state_nxt   = DATA;
`endif
                        end
                    end
                end
            end
`ifdef ADC_FRAME_HDR_EN
            HDR: begin
                if (frame_valid) ovf_nxt = 1'b1;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = wr_ptr;
                wr_data_nxt = word_c;
                ptr_nxt     = wr_ptr + ADDR_W'(1);
                idx_nxt     = idx + IDX_W'(1);
                state_nxt   = DATA;
            end
`endif
            DATA: begin
                if (frame_valid) ovf_nxt = 1'b1;
                if (idx < ndata_q) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = wr_ptr;
                    wr_data_nxt = word_c;
                    ptr_nxt     = wr_ptr + ADDR_W'(1);
                    idx_nxt     = idx + IDX_W'(1);
                end else begin
                    fcnt_nxt  = frame_cnt + 16'd1;
`ifdef ADC_FRAME_HDR_EN
                    seq_nxt   = seq + 16'd1;
`endif
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Enable rise restarts the ring and latches the decimation ratio
        if (en_rise_c) begin
            ptr_nxt   = '0;
            dec_nxt   = '0;
            ovf_nxt   = 1'b0;
            hr_nxt    = 2'b00;
            decim_nxt = decim;
`ifdef ADC_FRAME_HDR_EN
            seq_nxt   = '0;
`endif
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            comp_q      <= '0;
            ndata_q     <= '0;
            wr_ptr      <= '0;
            dec_cnt     <= '0;
            decim_q     <= '0;
            en_q        <= 1'b0;
            overflow    <= 1'b0;
            half_ready  <= 2'b00;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
`ifdef ADC_FRAME_HDR_EN
            seq         <= '0;
`endif
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            comp_q      <= comp_nxt;
            ndata_q     <= ndata_nxt;
            wr_ptr      <= ptr_nxt;
            dec_cnt     <= dec_nxt;
            decim_q     <= decim_nxt;
            en_q        <= enable;
            overflow    <= ovf_nxt;
            half_ready  <= hr_nxt;
            frame_cnt   <= fcnt_nxt;
            busy        <= busy_nxt;
            mem_wr_en   <= wr_en_nxt;
            mem_wr_addr <= wr_addr_nxt;
            mem_wr_data <= wr_data_nxt;
`ifdef ADC_FRAME_HDR_EN
            seq         <= seq_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_adc_frame_writer.sv
// Scoreboard bench for adc_frame_writer: expected writes are queued by stimulus, popped by a write monitor.
module tb_adc_frame_writer;

`ifdef ADC_FRAME_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [7:0]   decim;
    logic [7:0]   ch_mask;
    logic         frame_valid;
    logic [127:0] frame_data;
    logic [1:0]   half_ack;
    logic         mem_wr_en;
    logic [3:0]   mem_wr_addr;
    logic [31:0]  mem_wr_data;
    logic [1:0]   half_ready;
    logic         overflow;
    logic [15:0]  frame_cnt;
    logic         busy;

    adc_frame_writer #(.CH_NUM(8), .SMP_W(16), .ADDR_W(4), .DECIM_W(8)) dut (
        .sys_clk(clk), .rst(rst), .enable(enable), .decim(decim), .ch_mask(ch_mask),
        .frame_valid(frame_valid), .frame_data(frame_data), .half_ack(half_ack),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .half_ready(half_ready), .overflow(overflow), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [3:0]  exp_ptr = '0;
    logic [15:0] exp_seq = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Write monitor: every RAM write must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && mem_wr_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_wr_addr, mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_wr_addr !== mon_e.addr || mem_wr_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             mem_wr_addr, mem_wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d);
        exp_q.push_back({exp_ptr, d});
        exp_ptr = exp_ptr + 4'd1;
    endtask

    task automatic expf(input logic [31:0] w0, w1, w2, w3, input int n);
`ifdef ADC_FRAME_HDR_EN
        push({16'hA5A5, exp_seq});
        exp_seq = exp_seq + 16'd1;
`endif
        push(w0);
        if (n > 1) push(w1);
        if (n > 2) push(w2);
        if (n > 3) push(w3);
        exp_cnt++;
    endtask

    function automatic logic [127:0] ramp(input logic [15:0] b);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = b + 16'(i);
        return r;
    endfunction

    task automatic send(input logic [127:0] d, input logic [7:0] m);
        @(posedge clk); #1;
        frame_valid = 1'b1; frame_data = d; ch_mask = m;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reen(input logic [7:0] d);
        @(posedge clk); #1;
        enable = 1'b0; decim = d;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        exp_ptr = '0;
        exp_seq = '0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; decim = '0; ch_mask = '0;
        frame_valid = 1'b0; frame_data = '0; half_ack = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {29'd0, half_ready, overflow}, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        #1 rst = 1'b0;

        // Full mask, four packed words
        reen(8'd0);
        expf(32'h10011000, 32'h10031002, 32'h10051004, 32'h10071006, 4);
        send(ramp(16'h1000), 8'hFF);
        drain("full_mask_drain");
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Sparse mask with odd count, then an empty mask
        reen(8'd0);
        expf(32'h00020000, 32'h00000004, 32'h0, 32'h0, 2);
        send(ramp(16'h0000), 8'b00010101);
        send(ramp(16'h0000), 8'h00);
        drain("sparse_drain");
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);

        // Decimation by 4: frames 0 and 4 kept
        reen(8'd3);
        for (int f = 0; f < 8; f++) begin
            if (f % 4 == 0) expf(32'h10011000, 32'h10031002, 32'h10051004, 32'h10071006, 4);
            send(ramp(16'h1000), 8'hFF);
        end
        drain("decim_drain");
        check("frame_cnt_decim", 32'(frame_cnt), 32'd4);

`ifndef ADC_FRAME_HDR_EN
        // Ring fill, overflow protection and CPU acknowledge
        reen(8'd0);
        for (int f = 0; f < 4; f++) begin
            expf(32'h20012000, 32'h20032002, 32'h20052004, 32'h20072006, 4);
            send(ramp(16'h2000), 8'hFF);
            if (f == 1) check("half_ready_2f", 32'(half_ready), 32'd1);
        end
        check("half_ready_4f", 32'(half_ready), 32'd3);
        check("overflow_pre", 32'(overflow), 32'd0);
        send(ramp(16'h3000), 8'hFF);
        check("overflow_drop", 32'(overflow), 32'd1);
        check("half_ready_drop", 32'(half_ready), 32'd3);
        @(posedge clk); #1 half_ack = 2'b01;
        @(posedge clk); #1 half_ack = 2'b00;
        expf(32'h40014000, 32'h40034002, 32'h40054004, 32'h40074006, 4);
        frame_valid = 1'b1; frame_data = ramp(16'h4000); ch_mask = 8'hFF;
        @(posedge clk); #1 frame_valid = 1'b0;
        repeat (7) @(posedge clk);
        drain("ring_drain");
        check("half_ready_ack", 32'(half_ready), 32'd2);
        check("frame_cnt_ring", 32'(frame_cnt), 32'(exp_cnt));
`endif

        // Back-to-back frame_valid with enable falling mid-frame
        reen(8'd0);
        check("overflow_cleared", 32'(overflow), 32'd0);
        expf(32'h50015000, 32'h50035002, 32'h50055004, 32'h50075006, 4);
        @(posedge clk); #1;
        frame_valid = 1'b1; frame_data = ramp(16'h5000); ch_mask = 8'hFF;
        for (int c = 1; c <= HDR + 5; c++) begin
            @(posedge clk); #1;
            frame_valid = (c == 2);
            if (c == 2) begin
                enable = 1'b0;
                frame_data = ramp(16'h6000);
            end
            @(negedge clk);
            check($sformatf("busy_T+%0d", c), 32'(busy), 32'(c <= HDR + 4));
            if (c == HDR + 4) check("last_write_T+W", 32'(mem_wr_en), 32'd1);
        end
        drain("b2b_drain");
        check("overflow_b2b", 32'(overflow), 32'd1);
        send(ramp(16'h7000), 8'hFF);
        check("frame_cnt_b2b", 32'(frame_cnt), 32'(exp_cnt));

`ifdef ADC_FRAME_HDR_EN
        // Header sequence numbering
        reen(8'd0);
        push(32'hA5A50000); push(32'h00220011);
        send({112'd0, 16'h0022, 16'h0011}, 8'h03);
        push(32'hA5A50001); push(32'h00440033);
        send({112'd0, 16'h0044, 16'h0033}, 8'h03);
        drain("hdr_drain");
`endif

        // Reset in the middle of a frame
        reen(8'd0);
        if (HDR != 0) push(32'hA5A50000);
        else push(32'h10011000);
        @(posedge clk); #1;
        frame_valid = 1'b1; frame_data = ramp(16'h1000); ch_mask = 8'hFF;
        @(posedge clk); #1 frame_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mid_addr_data", {28'd0, mem_wr_addr} | mem_wr_data, 32'd0);
        check("rst_mid_flags", {28'd0, busy, half_ready, overflow}, 32'd0);
        check("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
        #1 rst = 1'b0;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
